// File: rtl/block_packer.sv
// rtl/block_packer.sv - packs a byte stream into 128-bit blocks and pushes them into fifo_buffer
// Optional build macro BLOCK_PACKER_PAD_EN selects PKCS#7 flush padding instead of zero padding.
module block_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    output logic             byte_ready,
    input  logic             flush,
    input  logic             fifo_full,
    output logic             fifo_write,
    output logic [127:0]     fifo_data,
    output logic [CNT_W-1:0] block_count
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PUSH = 1'b1
    } state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic [127:0] data_q;

    logic         accept;
    logic [127:0] shifted;
    logic [4:0]   cnt_eff;
    logic [7:0]   pad_byte;
    logic [7:0]   pad_shift;
    logic [7:0]   fill_shift;
    logic [127:0] pad_fill;
    logic [127:0] padded;

    assign byte_ready  = (state == FILL);
    assign fifo_write  = (state == PUSH) && !fifo_full;
    assign fifo_data   = data_q;

    always_comb begin
        accept     = byte_valid && byte_ready;
        shifted    = accept ? {data_q[119:0], byte_in} : data_q;
        cnt_eff    = {1'b0, cnt} + {4'b0000, accept};
        fill_shift = {cnt_eff, 3'b000};
        pad_shift  = 8'd128 - fill_shift;
`ifdef BLOCK_PACKER_PAD_EN
        pad_byte   = 8'd16 - {3'b000, cnt_eff};
`else
        pad_byte   = 8'h00;
`endif
        // Replicated pad shifted right leaves exactly the (16 - cnt_eff) low bytes set
        pad_fill   = {16{pad_byte}} >> fill_shift;
        padded     = (shifted << pad_shift) | pad_fill;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= FILL;
            cnt         <= 4'd0;
            data_q      <= 128'h0;
            block_count <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept && cnt == 4'd15) begin
                        data_q <= shifted;
                        cnt    <= 4'd0;
                        state  <= PUSH;
                    end else if (flush && cnt_eff != 5'd0) begin
                        data_q <= padded;
                        cnt    <= 4'd0;
                        state  <= PUSH;
                    end else if (accept) begin
                        data_q <= shifted;
                        cnt    <= cnt + 4'd1;
                    end
                end
                PUSH: begin
                    if (!fifo_full) begin
                        state       <= FILL;
                        cnt         <= 4'd0;
                        block_count <= block_count + 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_block_packer.sv
// tb/tb_block_packer.sv - directed self-checking bench for block_packer
module tb_block_packer;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic         byte_valid = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic         byte_ready;
    logic         flush = 1'b0;
    logic         fifo_full = 1'b0;
    logic         fifo_write;
    logic [127:0] fifo_data;
    logic [15:0]  block_count;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    int           write_count = 0;
    logic [127:0] last_write = 128'h0;

    block_packer #(.CNT_W(16)) dut (
        .clk(clk), .nRst(nRst), .byte_valid(byte_valid), .byte_in(byte_in),
        .byte_ready(byte_ready), .flush(flush), .fifo_full(fifo_full),
        .fifo_write(fifo_write), .fifo_data(fifo_data), .block_count(block_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (nRst && fifo_write) begin
            write_count = write_count + 1;
            last_write  = fifo_data;
        end
    end

    task automatic drive(input logic v, input logic [7:0] b, input logic f);
        @(posedge clk);
        #1;
        byte_valid = v;
        byte_in    = b;
        flush      = f;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        nRst = 1'b0; byte_valid = 1'b0; flush = 1'b0; fifo_full = 1'b0;
        @(posedge clk);
        #1;
        nRst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (byte_ready !== 1'b1 || fifo_write !== 1'b0) $display("FAIL reset_ctrl ready=%b write=%b want 1/0", byte_ready, fifo_write);
        else pass_cnt++;
        total_cnt++;
        if (fifo_data !== 128'h0 || block_count !== 16'd0) $display("FAIL reset_data data=%h count=%0d want 0/0", fifo_data, block_count);
        else pass_cnt++;
    endtask

    task automatic test_full_block();
        int w0;
        w0 = write_count;
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (fifo_write !== 1'b1 || write_count != w0) $display("FAIL full_latency write=%b writes=%0d want 1/%0d", fifo_write, write_count - w0, 0);
        else pass_cnt++;
        total_cnt++;
        if (fifo_data !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL full_data got %h want 000102030405060708090a0b0c0d0e0f", fifo_data);
        else pass_cnt++;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (write_count - w0 != 1 || block_count !== 16'd1) $display("FAIL full_count writes=%0d count=%0d want 1/1", write_count - w0, block_count);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        int w0;
        int bad;
        do_reset();
        w0 = write_count;
        bad = 0;
        fifo_full = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 8'hAA, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (byte_ready !== 1'b0 || fifo_write !== 1'b0 || fifo_data !== {16{8'hAA}}) bad++;
            if (i < 4) drive(1'b1, 8'h33, 1'b0);
        end
        total_cnt++;
        if (bad != 0) $display("FAIL bp_stall bad_cycles=%0d want 0", bad);
        else pass_cnt++;
        drive(1'b1, 8'h55, 1'b0);
        fifo_full = 1'b0;
        #1;
        total_cnt++;
        if (fifo_write !== 1'b1 || fifo_data !== {16{8'hAA}}) $display("FAIL bp_release write=%b data=%h want 1/aa..aa", fifo_write, fifo_data);
        else pass_cnt++;
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (fifo_data !== {{15{8'hAA}}, 8'h55} || write_count - w0 != 1 || last_write !== {16{8'hAA}})
            $display("FAIL bp_next data=%h writes=%0d want aa..aa55/1", fifo_data, write_count - w0);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int w0;
        logic [127:0] exp;
`ifdef BLOCK_PACKER_PAD_EN
        exp = 128'h1122330D0D0D0D0D0D0D0D0D0D0D0D0D;
`else
        exp = 128'h11223300000000000000000000000000;
`endif
        do_reset();
        w0 = write_count;
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (fifo_write !== 1'b1 || fifo_data !== exp) $display("FAIL flush_data write=%b got %h want %h", fifo_write, fifo_data, exp);
        else pass_cnt++;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (write_count - w0 != 1 || block_count !== 16'd1) $display("FAIL flush_count writes=%0d count=%0d want 1/1", write_count - w0, block_count);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int w0;
        w0 = write_count;
        for (int i = 0; i < 7; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        nRst = 1'b0;
        #1;
        total_cnt++;
        if (fifo_write !== 1'b0 || block_count !== 16'd0 || fifo_data !== 128'h0) $display("FAIL midreset_clear write=%b count=%0d data=%h want 0/0/0", fifo_write, block_count, fifo_data);
        else pass_cnt++;
        @(posedge clk);
        #1;
        nRst = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (write_count - w0 != 1 || last_write !== 128'h101112131415161718191A1B1C1D1E1F || block_count !== 16'd1)
            $display("FAIL midreset_block writes=%0d got %h count=%0d want 1/101112..1f/1", write_count - w0, last_write, block_count);
        else pass_cnt++;
    endtask

    task automatic test_flush_corners();
        int w0;
        do_reset();
        w0 = write_count;
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (write_count != w0 || byte_ready !== 1'b1 || block_count !== 16'd0) $display("FAIL flush_empty writes=%0d ready=%b want 0/1", write_count - w0, byte_ready);
        else pass_cnt++;
        for (int i = 0; i < 15; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b1, 8'h0F, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (fifo_write !== 1'b1 || fifo_data !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL flush16_data write=%b got %h want 1/000102..0f", fifo_write, fifo_data);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (write_count - w0 != 1 || block_count !== 16'd1) $display("FAIL flush16_count writes=%0d count=%0d want 1/1", write_count - w0, block_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_back_pressure();
        test_flush();
        test_mid_reset();
        test_flush_corners();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
